// File: rtl/cpu_pipe_pkg.sv
// Shared types and helpers for the P6 inter-stage pipeline registers.
`default_nettype none

package cpu_pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_REG_AW = 5;
    localparam int PIPE_TNEW_W = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [PIPE_DATA_W-1:0] pc;
        logic [PIPE_DATA_W-1:0] instr;
        logic [PIPE_REG_AW-1:0] a3;
        logic [PIPE_DATA_W-1:0] wd;
        logic [PIPE_TNEW_W-1:0] tnew;
    } pipe_payload_t;

    localparam pipe_payload_t PIPE_BUBBLE = '0;

    // Tnew fields up to 8 bits wide are supported; the result never wraps below zero.
    function automatic logic [7:0] tnew_dec(input logic [7:0] t);
        return (t == 8'd0) ? 8'd0 : t - 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_skid_slot.sv
// One valid+payload holding register; payload reads as zero whenever the slot is empty.
`default_nettype none

module pipe_skid_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (ld_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with 2-slot skid buffer, flush and Tnew decrement.
// Optional PIPE_STAGE_STAT_EN adds saturating stall/bubble cycle counters.
`default_nettype none

module pipe_stage_skid_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [REG_AW-1:0] in_a3,
    input  logic [DATA_W-1:0] in_wd,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [REG_AW-1:0] out_a3,
    output logic [DATA_W-1:0] out_wd,
    output logic [TNEW_W-1:0] out_tnew
`ifdef PIPE_STAGE_STAT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam int PW = 3*DATA_W + REG_AW + TNEW_W;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic          w_main_v, w_skid_v;
    logic [PW-1:0] w_main_data, w_skid_data;
    logic [PW-1:0] w_in_payload, w_main_din;
    logic [TNEW_W-1:0] w_tnew_dec;
    logic          w_accept, w_drain;
    logic          w_main_ld, w_main_clr, w_skid_ld, w_skid_clr;
    logic [1:0]    w_state;

    assign w_tnew_dec   = TNEW_W'(tnew_dec(8'(in_tnew)));
    assign w_in_payload = {in_pc, in_instr, in_a3, in_wd, w_tnew_dec};

    assign in_ready = ~w_skid_v;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = w_main_v & out_ready;
    assign w_state  = {w_main_v, w_skid_v};

    always_comb begin
        w_main_ld  = 1'b0;
        w_main_clr = 1'b0;
        w_skid_ld  = 1'b0;
        w_skid_clr = 1'b0;
        w_main_din = w_in_payload;
        if (flush) begin
            // Upstream entry offered alongside the flush is dropped.
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            case (w_state)
                ST_EMPTY: w_main_ld = w_accept;
                ST_BUSY: begin
                    if (w_accept && w_drain) begin
                        w_main_ld = 1'b1;
                    end else if (w_accept) begin
                        w_skid_ld = 1'b1;
                    end else if (w_drain) begin
                        w_main_clr = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_main_ld  = 1'b1;
                        w_main_din = w_skid_data;
                        w_skid_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_skid_slot #(.WIDTH(PW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (w_main_clr),
        .ld_i    (w_main_ld),
        .data_i  (w_main_din),
        .valid_o (w_main_v),
        .data_o  (w_main_data)
    );

    pipe_skid_slot #(.WIDTH(PW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (w_skid_clr),
        .ld_i    (w_skid_ld),
        .data_i  (w_in_payload),
        .valid_o (w_skid_v),
        .data_o  (w_skid_data)
    );

    logic [DATA_W-1:0] w_main_instr;

    // Empty slots hold an all-zero payload, so the bubble rule falls out of the slot.
    assign {out_pc, w_main_instr, out_a3, out_wd, out_tnew} = w_main_data;
    assign out_instr = w_main_v ? w_main_instr : DATA_W'(NOP_INSTR);
    assign out_valid = w_main_v;

`ifdef PIPE_STAGE_STAT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!out_valid && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire
